// File: rtl/ebus_xfer_pkg.sv
// ebus_xfer_pkg: shared EBUS state encoding and function codes
package ebus_xfer_pkg;
  typedef enum logic [2:0] {IDLE, ARB, SETUP, DEMAND, HOLD, DONE} state_t;
  localparam logic [0:2] F_CONO  = 3'd0;
  localparam logic [0:2] F_CONI  = 3'd1;
  localparam logic [0:2] F_DATAO = 3'd2;
  localparam logic [0:2] F_DATAI = 3'd3;
  function automatic logic is_input(input logic [0:2] f);
    return f[2];
  endfunction
endpackage

// File: rtl/ebus_xfer.sv
// ebus_xfer: sequences one EBUS transfer from request capture to done pulse
module ebus_xfer
  import ebus_xfer_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic [0:2]  reqFunc,
  input  logic [0:6]  reqDev,
  input  logic [0:35] reqData,
  output logic        reqReady,
  output logic        doneValid,
  output logic [0:35] doneData,
  output logic        doneTimeout,
  output logic        ebusReq,
  input  logic        ebusGrant,
  output logic [0:6]  ebusCS,
  output logic [0:2]  ebusF,
  output logic        ebusDemand,
  input  logic        ebusXfer,
  output logic [0:35] ebusDOut,
  output logic        ebusDOE,
  input  logic [0:35] ebusDIn
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state, state_n;
  logic [0:2] func_q;
  logic [0:6] dev_q;
  logic [0:35] data_q, rd_q;
  logic [7:0] cnt, cnt_inc;
  logic to_q, accept, to_hit, active, out_fn;
  assign accept = state == IDLE && reqValid;
  assign cnt_inc = cnt == 8'hff ? cnt : cnt + 8'd1;
  assign to_hit = state == DEMAND && !ebusXfer && cnt_inc >= TO;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state and bus/handshake outputs
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = reqValid ? ARB : IDLE;
      ARB:     state_n = ebusGrant ? SETUP : ARB;
      SETUP:   state_n = DEMAND;
      DEMAND:  state_n = ebusXfer ? HOLD : to_hit ? DONE : DEMAND;
      HOLD:    state_n = ebusXfer ? HOLD : DONE;
      default: state_n = IDLE;
    endcase
    active = state inside {SETUP, DEMAND, HOLD};
    out_fn = !is_input(func_q);
    reqReady = accept;
    doneValid = state == DONE;
    doneTimeout = doneValid && to_q;
    doneData = doneValid ? rd_q : '0;
    ebusReq = active || state == ARB;
    ebusCS = active ? dev_q : '0;
    ebusF = active ? func_q : '0;
    ebusDemand = state == DEMAND;
    ebusDOE = active && out_fn;
    ebusDOut = ebusDOE ? data_q : '0;
  end
  // captured operands, read data, timeout counter and flag
  always_ff @(posedge clk) begin
    if (reset) begin
      func_q <= '0;
      dev_q <= '0;
      data_q <= '0;
      rd_q <= '0;
      cnt <= '0;
      to_q <= 1'b0;
    end else begin
      if (accept) begin
        func_q <= reqFunc;
        dev_q <= reqDev;
        data_q <= reqData;
        rd_q <= '0;
        to_q <= 1'b0;
      end
      if (state == SETUP) cnt <= '0;
      if (state == DEMAND) cnt <= cnt_inc;
      if (state == DEMAND && ebusXfer && is_input(func_q)) rd_q <= ebusDIn;
      if (to_hit) to_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ebus_xfer.sv
// tb_ebus_xfer: table-driven check of ebus_xfer transfers, timeout and reset
module tb_ebus_xfer;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset, reqValid, reqReady, doneValid, doneTimeout, ebusReq, ebusGrant;
  logic ebusDemand, ebusXfer, ebusDOE;
  logic [0:2] reqFunc, ebusF;
  logic [0:6] reqDev, ebusCS;
  logic [0:35] reqData, doneData, ebusDOut, ebusDIn;
  always #5 clk = ~clk;
  ebus_xfer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqFunc(reqFunc), .reqDev(reqDev),
    .reqData(reqData), .reqReady(reqReady), .doneValid(doneValid), .doneData(doneData),
    .doneTimeout(doneTimeout), .ebusReq(ebusReq), .ebusGrant(ebusGrant), .ebusCS(ebusCS),
    .ebusF(ebusF), .ebusDemand(ebusDemand), .ebusXfer(ebusXfer), .ebusDOut(ebusDOut),
    .ebusDOE(ebusDOE), .ebusDIn(ebusDIn)
  );
  typedef struct {
    logic [0:2] func;
    logic [0:6] dev;
    logic [0:35] data;
    int gd, xd, xl;
    bit tog;
    logic [0:35] din;
    logic [0:35] exp_data;
    bit exp_to;
    int exp_lat;
  } vec_t;
  vec_t tv [9];
  int total = 0, bad = 0, lat;
  logic [0:87] act;
  assign act = {reqReady, doneValid, doneTimeout, doneData, ebusReq, ebusCS, ebusF, ebusDemand, ebusDOut, ebusDOE};
  localparam logic [0:87] ZERO = '0;
  function automatic logic [0:87] mk(input logic rr, input logic dv, input logic dt, input logic [0:35] dd,
                                     input logic rq, input logic [0:6] cs, input logic [0:2] f, input logic dm,
                                     input logic [0:35] dout, input logic doe);
    return {rr, dv, dt, dd, rq, cs, f, dm, dout, doe};
  endfunction
  task automatic chk(input string nm, input int c, input logic [0:87] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, e);
    end
  endtask
  task automatic chk_int(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int ph, prev, n, c;
    logic out_fn;
    logic [0:35] dout;
    out_fn = !v.func[2];
    dout = out_fn ? v.data : '0;
    reqValid = 1'b1;
    reqFunc = v.func;
    reqDev = v.dev;
    reqData = v.data;
    ebusGrant = 1'b0;
    ebusXfer = 1'b0;
    ebusDIn = v.din;
    #1 chk("accept", 0, mk(1, 0, 0, '0, 0, '0, '0, 0, '0, 0));
    ph = 1;
    n = 0;
    c = 0;
    lat = -1;
    while (ph != 0 && c < 200) begin
      step;
      c++;
      prev = ph;
      reqValid = (v.tog && ph == 1) ? c[0] : 1'b0;
      reqFunc = ~v.func;
      reqDev = ~v.dev;
      reqData = ~v.data;
      case (ph)
        1: begin
          ebusGrant = n >= v.gd;
          #1 chk("arb", c, mk(0, 0, 0, '0, 1, '0, '0, 0, '0, 0));
          ph = ebusGrant ? 2 : 1;
        end
        2: begin
          ebusGrant = 1'b0;
          #1 chk("setup", c, mk(0, 0, 0, '0, 1, v.dev, v.func, 0, dout, out_fn));
          ph = 3;
        end
        3: begin
          ebusXfer = n >= v.xd;
          #1 chk("demand", c, mk(0, 0, 0, '0, 1, v.dev, v.func, 1, dout, out_fn));
          ph = ebusXfer ? 4 : (n + 1 >= TO) ? 5 : 3;
        end
        4: begin
          ebusXfer = n < v.xl;
          #1 chk("hold", c, mk(0, 0, 0, '0, 1, v.dev, v.func, 0, dout, out_fn));
          ph = ebusXfer ? 4 : 5;
        end
        default: begin
          ebusXfer = 1'b0;
          #1 chk("done", c, mk(0, 1, v.exp_to, v.exp_data, 0, '0, '0, 0, '0, 0));
          lat = c;
          ph = 0;
        end
      endcase
      n = (ph == prev) ? n + 1 : 0;
    end
    chk_int("latency", lat, v.exp_lat);
    step;
    #1 chk("idle", c + 1, ZERO);
  endtask
  initial begin
    tv[0] = '{3'd1, 7'o014, 36'o0, 0, 2, 0, 1'b0, 36'o123456_701234, 36'o123456_701234, 1'b0, 7};
    tv[1] = '{3'd2, 7'o040, 36'o777000_000777, 0, 0, 0, 1'b0, 36'o555555_555555, 36'o0, 1'b0, 5};
    tv[2] = '{3'd0, 7'o001, 36'o000000_000017, 0, 99, 0, 1'b0, 36'o0, 36'o0, 1'b1, 7};
    tv[3] = '{3'd3, 7'o177, 36'o0, 10, 1, 0, 1'b1, 36'o000000_000001, 36'o000000_000001, 1'b0, 16};
    tv[4] = '{3'd3, 7'o100, 36'o0, 0, 0, 2, 1'b0, 36'o525252_525252, 36'o525252_525252, 1'b0, 7};
    tv[5] = '{3'd1, 7'o002, 36'o0, 0, 3, 0, 1'b0, 36'o700000_000007, 36'o700000_000007, 1'b0, 8};
    tv[6] = '{3'd3, 7'o003, 36'o0, 0, 99, 0, 1'b0, 36'o777777_777777, 36'o0, 1'b1, 7};
    tv[7] = '{3'd5, 7'o004, 36'o0, 0, 0, 0, 1'b0, 36'o012345_670123, 36'o012345_670123, 1'b0, 5};
    tv[8] = '{3'd6, 7'o005, 36'o000000_000123, 2, 1, 1, 1'b0, 36'o111111_111111, 36'o0, 1'b0, 9};
    reset = 1'b1;
    reqValid = 1'b0;
    reqFunc = '0;
    reqDev = '0;
    reqData = '0;
    ebusGrant = 1'b0;
    ebusXfer = 1'b0;
    ebusDIn = '0;
    step;
    step;
    chk("reset", 0, ZERO);
    reset = 1'b0;
    step;
    for (int i = 0; i < 9; i++) run_vec(tv[i]);
    reqValid = 1'b1;
    reqFunc = 3'd1;
    reqDev = 7'o014;
    ebusDIn = 36'o123456_701234;
    step;
    reqValid = 1'b0;
    ebusGrant = 1'b1;
    step;
    ebusGrant = 1'b0;
    step;
    chk("rst_pre", 3, mk(0, 0, 0, '0, 1, 7'o014, 3'd1, 1, '0, 0));
    reset = 1'b1;
    step;
    chk("rst_demand", 4, ZERO);
    reset = 1'b0;
    ebusXfer = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      chk("post_rst", 5 + k, ZERO);
    end
    ebusXfer = 1'b0;
    run_vec(tv[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
